// File: rtl/tick_updown_counter_if.sv
// Control and status bundle for tick_updown_counter.
// The bus carries level-sensitive controls only: there is no valid/ready
// handshake. Every control is sampled on each rising clock_in edge, and the
// status outputs (counter_out, tick, tc) are registered and stable between
// edges.
interface tick_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             up_dn;
  logic             sat_mode;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] counter_out;
  logic             tick;
  logic             tc;

  modport master (
    output enable, up_dn, sat_mode, clear, load, load_val,
    input  counter_out, tick, tc
  );

  modport slave (
    input  enable, up_dn, sat_mode, clear, load, load_val,
    output counter_out, tick, tc
  );
endinterface

// File: rtl/tick_updown_counter.sv
// Prescaled up/down counter.
// A prescaler divides clock_in by DIVISOR. Each rollover is a "step", which
// moves the counter up or down by one, wrapping or saturating at 0..MAX_VAL.
// tick pulses in the cycle after every step. tc pulses when a step lands on a
// range boundary. Priority on each edge is clear, then load, then step.
module tick_updown_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter int unsigned     DIVISOR = 200000000,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  tick_updown_counter_if.slave  bus
);

  localparam int unsigned      PW         = $clog2(longint'(DIVISOR) + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIVISOR - 1);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);

  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] load_sat;
  logic             step;
  logic             tick_q;
  logic             tick_d;
  logic             tc_q;
  logic             tc_d;

  // Next-state logic for the prescaler, the counter and the two pulses.
  always_comb begin
    step     = bus.enable && (presc_q == PRESC_LAST);
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    tc_d     = 1'b0;
    load_sat = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;

    if (bus.enable) begin
      presc_d = step ? '0 : presc_q + PW'(1);
    end

    if (bus.clear) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      // A load still lets the prescaler run, so tick keeps its phase.
      tick_d = step;
      if (bus.load) begin
        cnt_d = load_sat;
      end else if (step) begin
        if (bus.up_dn) begin
          if (cnt_q == MAX_W) begin
            tc_d = 1'b1;
            if (!bus.sat_mode) cnt_d = '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            tc_d = 1'b1;
            if (!bus.sat_mode) cnt_d = MAX_W;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.counter_out = cnt_q;
  assign bus.tick        = tick_q;
  assign bus.tc          = tc_q;

endmodule

// File: tb/tb_tick_updown_counter.sv
// Bench for tick_updown_counter. Two instances share one stimulus stream and
// differ only in MAX_VAL (15 and 9). A behavioural model predicts every
// registered output, and directed sequences pin the model with literals.
module tb_tick_updown_counter;

  localparam int W   = 4;
  localparam int DIV = 4;
  localparam int MXA = 15;
  localparam int MXB = 9;

  // ---------------- clock / reset ----------------
  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clock_in = ~clock_in;

  logic         enable   = 1'b0;
  logic         up_dn    = 1'b1;
  logic         sat_mode = 1'b0;
  logic         clear    = 1'b0;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;

  tick_updown_counter_if #(.WIDTH(W)) bus_a ();
  tick_updown_counter_if #(.WIDTH(W)) bus_b ();

  assign bus_a.enable   = enable;
  assign bus_a.up_dn    = up_dn;
  assign bus_a.sat_mode = sat_mode;
  assign bus_a.clear    = clear;
  assign bus_a.load     = load;
  assign bus_a.load_val = load_val;
  assign bus_b.enable   = enable;
  assign bus_b.up_dn    = up_dn;
  assign bus_b.sat_mode = sat_mode;
  assign bus_b.clear    = clear;
  assign bus_b.load     = load;
  assign bus_b.load_val = load_val;

  tick_updown_counter #(.WIDTH(W), .DIVISOR(DIV), .MAX_VAL(MXA)) dut_a (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus_a)
  );

  tick_updown_counter #(.WIDTH(W), .DIVISOR(DIV), .MAX_VAL(MXB)) dut_b (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: prescaler phase as an integer mod DIV, counts as
  // integers in 0..max, boundary rules applied directly.
  int m_phase;
  int m_cnt [2];
  bit m_tc  [2];
  bit m_tick;
  int mx    [2] = '{MXA, MXB};

  // Packed expectation: {tick, tc_b, cnt_b, tc_a, cnt_a}
  logic [2*W+2:0] exp_q[$];

  task automatic model_reset();
    m_phase = 0;
    m_tick  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit stp;
    int lv;
    stp = enable && (m_phase == DIV - 1);
    if (clear)       m_phase = 0;
    else if (enable) m_phase = (m_phase + 1) % DIV;
    m_tick = stp && !clear;
    for (int i = 0; i < 2; i++) begin
      m_tc[i] = 1'b0;
      if (clear) begin
        m_cnt[i] = 0;
      end else if (load) begin
        lv = int'(load_val);
        m_cnt[i] = (lv > mx[i]) ? mx[i] : lv;
      end else if (stp) begin
        if (up_dn) begin
          if (m_cnt[i] == mx[i]) begin
            m_tc[i] = 1'b1;
            if (!sat_mode) m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            m_tc[i] = 1'b1;
            if (!sat_mode) m_cnt[i] = mx[i];
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  endtask

  // Model update on every clock or reset event, compare 1 time unit later.
  always begin
    logic [2*W+2:0] e;
    @(posedge clock_in or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_edge();
    exp_q.push_back({m_tick, m_tc[1], W'(m_cnt[1]), m_tc[0], W'(m_cnt[0])});
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("cnt_a", 32'(bus_a.counter_out), 32'(e[W-1:0]));
      check("tc_a",  32'(bus_a.tc),          32'(e[W]));
      check("cnt_b", 32'(bus_b.counter_out), 32'(e[2*W:W+1]));
      check("tc_b",  32'(bus_b.tc),          32'(e[2*W+1]));
      check("tick_a", 32'(bus_a.tick),       32'(e[2*W+2]));
      check("tick_b", 32'(bus_b.tick),       32'(e[2*W+2]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clock_in);
    #2;
  endtask

  task automatic drive_random();
    enable   = ($urandom_range(0, 9) < 8);
    up_dn    = 1'($urandom_range(0, 1));
    sat_mode = 1'($urandom_range(0, 1));
    clear    = ($urandom_range(0, 49) == 0);
    load     = ($urandom_range(0, 19) == 0);
    load_val = W'($urandom_range(0, 15));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    edges(2);
    check("rst_cnt_a", 32'(bus_a.counter_out), 32'd0);
    check("rst_tick",  32'(bus_a.tick),        32'd0);
    reset_n  = 1'b1;
    enable   = 1'b1;
    up_dn    = 1'b1;
    sat_mode = 1'b0;

    // Up, wrap, 64 enabled cycles.
    edges(3);
    check("up_tick_e3", 32'(bus_a.tick), 32'd0);
    edges(1);
    check("up_tick_e4", 32'(bus_a.tick), 32'd1);
    check("up_cnt_e4",  32'(bus_a.counter_out), 32'd1);
    edges(1);
    check("up_tick_e5", 32'(bus_a.tick), 32'd0);
    edges(55);
    check("up_cnt_e60", 32'(bus_a.counter_out), 32'd15);
    check("up_tc_e60",  32'(bus_a.tc), 32'd0);
    edges(4);
    check("up_cnt_e64", 32'(bus_a.counter_out), 32'd0);
    check("up_tc_e64",  32'(bus_a.tc), 32'd1);
    check("up_cntb_e64", 32'(bus_b.counter_out), 32'd6);

    // Down, saturate, from load of 2.
    clear = 1'b1;
    edges(1);
    check("clr_cnt", 32'(bus_a.counter_out), 32'd0);
    clear    = 1'b0;
    load     = 1'b1;
    load_val = 4'd2;
    up_dn    = 1'b0;
    sat_mode = 1'b1;
    edges(1);
    check("ld2_cnt", 32'(bus_b.counter_out), 32'd2);
    load = 1'b0;
    edges(3);
    check("dn_cnt1",  32'(bus_b.counter_out), 32'd1);
    check("dn_tick1", 32'(bus_b.tick), 32'd1);
    edges(4);
    check("dn_cnt0",  32'(bus_b.counter_out), 32'd0);
    check("dn_tc0",   32'(bus_b.tc), 32'd0);
    edges(4);
    check("dn_sat_cnt", 32'(bus_b.counter_out), 32'd0);
    check("dn_sat_tc",  32'(bus_b.tc), 32'd1);

    // Load clamps to MAX_VAL and beats a coincident step.
    edges(3);
    load     = 1'b1;
    load_val = 4'd13;
    edges(1);
    check("ld13_cnt_b", 32'(bus_b.counter_out), 32'd9);
    check("ld13_cnt_a", 32'(bus_a.counter_out), 32'd13);
    check("ld13_tick",  32'(bus_b.tick), 32'd1);
    check("ld13_tc_b",  32'(bus_b.tc), 32'd0);

    // Clear and load together from 7.
    load_val = 4'd7;
    edges(1);
    check("ld7_cnt", 32'(bus_b.counter_out), 32'd7);
    clear = 1'b1;
    edges(1);
    check("clrld_cnt",  32'(bus_b.counter_out), 32'd0);
    check("clrld_tick", 32'(bus_b.tick), 32'd0);
    clear    = 1'b0;
    load     = 1'b0;
    up_dn    = 1'b1;
    sat_mode = 1'b0;
    edges(3);
    check("clr_tick_e3", 32'(bus_b.tick), 32'd0);
    edges(1);
    check("clr_tick_e4", 32'(bus_b.tick), 32'd1);
    check("clr_cnt_e4",  32'(bus_b.counter_out), 32'd1);

    // Enable dropped for 10 cycles mid-prescale.
    edges(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check("dis_tick", 32'(bus_b.tick), 32'd0);
    end
    check("dis_cnt", 32'(bus_b.counter_out), 32'd1);
    enable = 1'b1;
    edges(1);
    check("res_tick_e1", 32'(bus_b.tick), 32'd0);
    edges(1);
    check("res_tick_e2", 32'(bus_b.tick), 32'd1);
    check("res_cnt",     32'(bus_b.counter_out), 32'd2);

    // Asynchronous reset between edges with counter at 5.
    load     = 1'b1;
    load_val = 4'd5;
    edges(1);
    load = 1'b0;
    check("ld5_cnt", 32'(bus_b.counter_out), 32'd5);
    @(negedge clock_in);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cnt",  32'(bus_b.counter_out), 32'd0);
    check("arst_tick", 32'(bus_b.tick), 32'd0);
    @(negedge clock_in);
    reset_n = 1'b1;
    edges(3);
    check("rel_tick_e3", 32'(bus_b.tick), 32'd0);
    edges(1);
    check("rel_tick_e4", 32'(bus_b.tick), 32'd1);
    check("rel_cnt_e4",  32'(bus_b.counter_out), 32'd1);

    // Randomized stream against the model.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #4;
        reset_n = 1'b1;
      end
      edges(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tick_updown_counter.md
TICK_UPDOWN_COUNTER -- requirements
Module: tick_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal range 1..32).
REQ-002 SHALL have parameter DIVISOR, default 200000000, meaning clock_in cycles per count tick (legal range >= 1).
REQ-003 SHALL have parameter MAX_VAL, default 2**WIDTH-1, meaning terminal value of the count range 0..MAX_VAL (legal range 1..2**WIDTH-1).
REQ-004 SHALL have port clock_in  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  high: prescaler runs; low: prescaler and counter frozen.
REQ-007 SHALL have port up_dn  input  1  count direction per step: 1 = up, 0 = down.
REQ-008 SHALL have port sat_mode  input  1  1 = saturate at range boundary, 0 = wrap.
REQ-009 SHALL have port clear  input  1  synchronous clear of counter and prescaler.
REQ-010 SHALL have port load  input  1  synchronous load of load_val into counter.
REQ-011 SHALL have port load_val  input  WIDTH  value to load.
REQ-012 SHALL have port counter_out  output  WIDTH  current count, registered.
REQ-013 SHALL have port tick  output  1  registered one-cycle pulse, asserted on each prescaler rollover.
REQ-014 SHALL have port tc  output  1  registered one-cycle pulse, asserted when a step hits the boundary (wrap or saturate).

Function
REQ-015 SHALL keep the prescaler at ceil(log2(DIVISOR+1)) bits and never generate a derived clock; all logic is clocked by clock_in.
REQ-016 SHALL, with enable=1, advance the prescaler 0..DIVISOR-1 and set it to 0 after DIVISOR-1; the rollover edge is the "step" edge.
REQ-017 SHALL assert tick for exactly one cycle, in the cycle after each step edge; with DIVISOR=1, tick is high on every enabled cycle.
REQ-018 SHALL, with enable=0, hold the prescaler and counter_out and drive tick=0 and tc=0.
REQ-019 SHALL apply this priority on each edge: clear > load > step.
REQ-020 SHALL, on clear, set counter_out=0 and prescaler=0 regardless of enable, and suppress tick and tc that cycle.
REQ-021 SHALL, on load (no clear), set counter_out=min(load_val, MAX_VAL) regardless of enable, leave the prescaler running unaffected, and discard any coincident step (tick still pulses, tc=0).
REQ-022 SHALL, on a step with up_dn=1: counter < MAX_VAL -> +1; counter = MAX_VAL -> 0 if sat_mode=0, hold if sat_mode=1; tc=1 in the boundary case.
REQ-023 SHALL, on a step with up_dn=0: counter > 0 -> -1; counter = 0 -> MAX_VAL if sat_mode=0, hold if sat_mode=1; tc=1 in the boundary case.
REQ-024 SHALL sample up_dn and sat_mode only on step edges; changes between steps have no effect.
REQ-025 SHALL, when counter_out > MAX_VAL cannot occur, keep all arithmetic modulo WIDTH bits with no overflow beyond MAX_VAL.

Reset
REQ-026 SHALL, on reset_n=0, immediately and asynchronously set counter_out=0, prescaler=0, tick=0, tc=0.
REQ-027 SHALL release reset synchronously: the first prescaler increment occurs on the first clock_in rising edge with reset_n=1; reset mid-count discards the partial prescale.

Verification
REQ-028 SHALL cover: DIVISOR=4, WIDTH=4, up, wrap, enable=1 for 64 cycles -> tick every 4th cycle, counter 0..15 then 0, tc pulse with the 15->0 step.
REQ-029 SHALL cover: DIVISOR=4, MAX_VAL=9, down, sat_mode=1 from load_val=2 -> 2,1,0,0; tc on each step at 0.
REQ-030 SHALL cover: MAX_VAL=9, load_val=13 -> counter_out=9; load and step in the same cycle -> load wins, tc=0.
REQ-031 SHALL cover: clear and load asserted together with counter=7 -> counter_out=0, prescaler restarts, next tick exactly DIVISOR cycles later.
REQ-032 SHALL cover: enable dropped for 10 cycles mid-prescale -> counter_out and tick phase resume unchanged, tick=0 while disabled.
REQ-033 SHALL cover: reset_n pulsed low between clock edges with counter=5 -> outputs 0 before next edge, first tick DIVISOR cycles after release.
